// File: rtl/uart_tx_queue.sv
// Buffered uart transmit front-end: DEPTH-entry FIFO drained over the tx_en/tx_rdy
// handshake, with full/empty/count status, sticky overflow and optional CR -> CR LF.
module uart_tx_queue #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned CRLF_EXPAND = 1
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              overflow,
    input  logic              ovf_clr,
    input  logic              tx_rdy,
    output logic              tx_en,
    output logic [DATA_W-1:0] tx_data
);

    localparam bit                expand_on = (CRLF_EXPAND != 0) && (DATA_W == 8);
    localparam logic [DATA_W-1:0] cr_char   = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] lf_char   = DATA_W'(8'h0A);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;
    logic              drop;
    logic [AW:0]       count_n;
    logic              lf_pend;
    logic              lf_pend_n;
    logic              tx_en_n;
    logic [DATA_W-1:0] tx_data_n;

    // Full is the registered flag, so a push while full drops even if a pop frees a slot.
    assign push    = wr_en & ~full;
    assign drop    = wr_en & full;
    assign head    = mem[rd_ptr];
    assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk_50m) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            lf_pend  <= 1'b0;
            tx_en    <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_n;
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(pop);
            count    <= count_n;
            full     <= (count_n == (AW+1)'(DEPTH));
            empty    <= (count_n == '0);
            overflow <= drop | (overflow & ~ovf_clr);
            lf_pend  <= lf_pend_n;
            tx_en    <= tx_en_n;
            tx_data  <= tx_data_n;
        end
    end

    // Drain FSM: a pending LF goes out before the next queued byte.
    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        lf_pend_n = lf_pend;
        tx_en_n   = tx_en;
        tx_data_n = tx_data;
        case (state)
            IDLE: begin
                tx_en_n = 1'b0;
                if (tx_rdy && lf_pend) begin
                    tx_data_n = lf_char;
                    tx_en_n   = 1'b1;
                    lf_pend_n = 1'b0;
                    state_n   = BUSY;
                end else if (tx_rdy && !empty) begin
                    tx_data_n = head;
                    tx_en_n   = 1'b1;
                    pop       = 1'b1;
                    state_n   = BUSY;
                    if (expand_on && (head == cr_char)) begin
                        lf_pend_n = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!tx_rdy) begin
                    tx_en_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                tx_en_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus queues expected uart bytes, monitors
// compare every tx_en rise; a second instance covers CRLF_EXPAND=0.
module tb_uart_tx_queue;

    logic       clk_50m = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty, overflow, ovf_clr, tx_rdy, tx_en;
    logic [4:0] count;
    logic [7:0] tx_data;

    logic       wr_en0;
    logic [7:0] wr_data0;
    logic       full0, empty0, overflow0, tx_en0;
    logic       ovf_clr0 = 1'b0;
    logic       tx_rdy0;
    logic [4:0] count0;
    logic [7:0] tx_data0;

    logic       hold, uart_ready, uart_stuck;
    int         frame_max;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         tx_starts = 0;
    int         max_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp0_q[$];

    always #10 clk_50m = ~clk_50m;

    assign tx_rdy  = uart_ready & ~hold;
    assign tx_rdy0 = ~tx_en0;

    uart_tx_queue u_dut (
        .clk_50m(clk_50m), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .ovf_clr(ovf_clr), .tx_rdy(tx_rdy), .tx_en(tx_en), .tx_data(tx_data)
    );

    uart_tx_queue #(.CRLF_EXPAND(0)) u_dut0 (
        .clk_50m(clk_50m), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0),
        .full(full0), .empty(empty0), .count(count0), .overflow(overflow0),
        .ovf_clr(ovf_clr0), .tx_rdy(tx_rdy0), .tx_en(tx_en0), .tx_data(tx_data0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One push on the main instance; accepted bytes join the expected uart stream.
    task automatic push(input logic [7:0] b, input bit acc);
        @(negedge clk_50m);
        wr_en   = 1'b1;
        wr_data = b;
        if (acc) begin
            exp_q.push_back(b);
            if (b == 8'h0D) exp_q.push_back(8'h0A);
        end
        @(posedge clk_50m);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic push0(input logic [7:0] b);
        @(negedge clk_50m);
        wr_en0   = 1'b1;
        wr_data0 = b;
        exp0_q.push_back(b);
        @(posedge clk_50m);
        #1;
        wr_en0 = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_50m);
            #1;
            if (exp_q.size() == 0 && exp0_q.size() == 0 && empty && !tx_en
                && uart_ready && !tx_en0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", 32'(done), 32'd1);
        repeat (2) @(posedge clk_50m);
        #1;
    endtask

    // Uart model: accepts on tx_en while ready, then stays busy for a random frame time.
    initial begin
        uart_ready = 1'b1;
        forever begin
            @(posedge clk_50m);
            #1;
            if (tx_en && tx_rdy && !uart_stuck) begin
                uart_ready = 1'b0;
                repeat (int'($urandom_range(frame_max, 1))) @(posedge clk_50m);
                #1;
                uart_ready = 1'b1;
            end
        end
    end

    // Monitor: every tx_en rise is one character seen by the uart.
    initial begin
        logic       prev  = 1'b0;
        logic       prev0 = 1'b0;
        logic [7:0] e;
        forever begin
            @(posedge clk_50m);
            #1;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (tx_en && !prev) begin
                tx_starts++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_tx: got %0h, expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data_order", 32'(tx_data), 32'(e));
                end
            end
            if (tx_en0 && !prev0) begin
                if (exp0_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_tx0: got %0h, expected none", tx_data0);
                end else begin
                    e = exp0_q.pop_front();
                    check("tx0_data_order", 32'(tx_data0), 32'(e));
                end
            end
            prev  = tx_en;
            prev0 = tx_en0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts_before;
        int g;
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
        wr_en0 = 1'b0; wr_data0 = '0;
        hold = 1'b0; uart_stuck = 1'b0; frame_max = 2;
        repeat (3) @(posedge clk_50m);
        @(negedge clk_50m);
        rst = 1'b0;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);

        // Single byte latency and handshake.
        push(8'h41, 1'b1);
        check("t1_count", 32'(count), 32'd1);
        @(posedge clk_50m); #1;
        check("t1_tx_en_hi", 32'(tx_en), 32'd1);
        check("t1_tx_data", 32'(tx_data), 32'h41);
        @(posedge clk_50m); #1;
        check("t1_tx_en_lo", 32'(tx_en), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);
        wait_drain(100);

        // Fill, overflow, clear, drain in order (0x0D expands to 0x0D 0x0A).
        hold = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
        check("t2_full", 32'(full), 32'd1);
        check("t2_count", 32'(count), 32'd16);
        check("t2_ovf_before", 32'(overflow), 32'd0);
        push(8'hEE, 1'b0);
        check("t2_ovf_set", 32'(overflow), 32'd1);
        check("t2_count_keep", 32'(count), 32'd16);
        @(negedge clk_50m); ovf_clr = 1'b1;
        @(posedge clk_50m); #1; ovf_clr = 1'b0;
        check("t2_ovf_clr", 32'(overflow), 32'd0);
        hold = 1'b0;
        wait_drain(400);

        // Wrap: 40 flow-controlled bytes with random frame times.
        frame_max = 4;
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            g = 0;
            while (full && g < 200) begin
                @(posedge clk_50m); #1;
                g++;
            end
            push(8'(i * 7 + 3), 1'b1);
            if (i % 9 == 8) repeat (5) @(posedge clk_50m);
        end
        wait_drain(1500);
        check("t3_max_count_ok", 32'(max_cnt <= 16), 32'd1);
        check("t3_no_overflow", 32'(overflow), 32'd0);
        frame_max = 2;

        // CR expansion on, and the same string through the non-expanding instance.
        push(8'h48, 1'b1);
        push(8'h0D, 1'b1);
        push(8'h69, 1'b1);
        push0(8'h48);
        push0(8'h0D);
        push0(8'h69);
        wait_drain(200);
        check("t4_dut0_empty", 32'(empty0), 32'd1);
        check("t4_dut0_count", 32'(count0), 32'd0);
        check("t4_dut0_full", 32'(full0), 32'd0);
        check("t4_dut0_ovf", 32'(overflow0), 32'd0);

        // Push and pop in one cycle while full: push dropped.
        hold = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h50 + 8'(i), 1'b1);
        check("t5_full", 32'(full), 32'd1);
        @(negedge clk_50m);
        hold = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
        @(posedge clk_50m); #1;
        wr_en = 1'b0; hold = 1'b1;
        check("t5_count15", 32'(count), 32'd15);
        check("t5_ovf", 32'(overflow), 32'd1);
        check("t5_not_full", 32'(full), 32'd0);
        push(8'h80, 1'b1);
        check("t5_refull", 32'(full), 32'd1);
        @(negedge clk_50m);
        wr_en = 1'b1; wr_data = 8'h81; ovf_clr = 1'b1;
        @(posedge clk_50m); #1;
        wr_en = 1'b0; ovf_clr = 1'b0;
        check("t5_set_wins", 32'(overflow), 32'd1);
        check("t5_count16", 32'(count), 32'd16);
        @(negedge clk_50m); ovf_clr = 1'b1;
        @(posedge clk_50m); #1; ovf_clr = 1'b0;
        check("t5_ovf_clr", 32'(overflow), 32'd0);
        hold = 1'b0;
        wait_drain(400);

        // Reset while BUSY with an LF pending and 5 bytes queued.
        uart_stuck = 1'b1;
        push(8'h0D, 1'b1);
        for (int i = 0; i < 5; i++) push(8'h61 + 8'(i), 1'b1);
        check("t6_busy_tx_en", 32'(tx_en), 32'd1);
        check("t6_count5", 32'(count), 32'd5);
        @(negedge clk_50m); rst = 1'b1;
        @(posedge clk_50m); #1;
        rst = 1'b0;
        exp_q.delete();
        check("t6_tx_en", 32'(tx_en), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        uart_stuck = 1'b0;
        starts_before = tx_starts;
        repeat (12) @(posedge clk_50m);
        #1;
        check("t6_no_lf_after_rst", 32'(tx_starts), 32'(starts_before));
        check("t6_tx_en_idle", 32'(tx_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
